// File: rtl/seq_mult.sv
// Iterative shift-and-add multiplier. It handles unsigned or two's-complement operands, WIDTH+1 edges from accept to out_valid.
// Backpressure: in_ready is high only in IDLE, and out_p/out_valid hold in DONE until out_ready.
module seq_mult #(
  parameter int WIDTH     = 24,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     sum;
  logic               last_iter;

  // Negating the most-negative value wraps back to 2^(WIDTH-1), which is its exact unsigned magnitude.
  always_comb begin
    sgn       = SIGNED_EN && in_signed;
    a_mag     = (sgn && in_a[WIDTH-1]) ? -in_a : in_a;
    b_mag     = (sgn && in_b[WIDTH-1]) ? -in_b : in_b;
    pp        = mcand & {WIDTH{prod[0]}};
    sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, pp};
    last_iter = (cnt == CW'(WIDTH-1));
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      out_p     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mcand <= a_mag;
            prod  <= {{WIDTH{1'b0}}, b_mag};
            neg   <= sgn && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            cnt   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          // The carry out of the upper-half add becomes the new MSB as the register shifts right.
          prod <= {sum, prod[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (last_iter) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          out_p     <= neg ? -prod : prod;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
